// File: rtl/mux_nto1_reg.sv
// N-to-1 registered mux with explicit or round-robin channel selection and valid/ready handshake.
// Optional out_parity output is enabled by defining MUX_NTO1_PARITY_EN.
module mux_nto1_reg #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 8,
   localparam int SEL_W   = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic [SEL_W-1:0]          sel,
   input  logic                      mode,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_chan,
   output logic                      out_valid,
`ifdef MUX_NTO1_PARITY_EN
   output logic                      out_parity,
`endif
   input  logic                      out_ready
);

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [SEL_W-1:0] rr_ptr;
   logic [SEL_W-1:0] cand;
   logic             cand_valid;
   logic [SEL_W-1:0] rr_hi;
   logic             rr_hi_vld;
   logic [SEL_W-1:0] rr_lo;
   logic             rr_lo_vld;
   logic [WIDTH-1:0] cand_data;
   logic             load;

   assign out_valid = (state == HOLD);

   // Round-robin: lowest valid index at or above rr_ptr, else lowest valid index overall.
   always_comb begin
      rr_hi     = '0;
      rr_hi_vld = 1'b0;
      rr_lo     = '0;
      rr_lo_vld = 1'b0;
      for (int k = CHANNELS - 1; k >= 0; k--) begin
         if (in_valid[k]) begin
            rr_lo     = SEL_W'(k);
            rr_lo_vld = 1'b1;
            if (SEL_W'(k) >= rr_ptr) begin
               rr_hi     = SEL_W'(k);
               rr_hi_vld = 1'b1;
            end
         end
      end
   end

   always_comb begin
      cand       = '0;
      cand_valid = 1'b0;
      if (!mode) begin
         // An out-of-range sel matches no channel, so nothing is granted.
         for (int k = 0; k < CHANNELS; k++) begin
            if (sel == SEL_W'(k)) begin
               cand       = sel;
               cand_valid = in_valid[k];
            end
         end
      end else if (rr_hi_vld) begin
         cand       = rr_hi;
         cand_valid = 1'b1;
      end else begin
         cand       = rr_lo;
         cand_valid = rr_lo_vld;
      end
   end

   always_comb begin
      cand_data = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (cand == SEL_W'(k)) begin
            cand_data = in_data[k*WIDTH +: WIDTH];
         end
      end
   end

   assign load = cand_valid && (!out_valid || out_ready) && !rst;

   always_comb begin
      in_ready = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         in_ready[k] = load && (cand == SEL_W'(k));
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (load) state_nxt = HOLD;
         HOLD: begin
            if (load) begin
               state_nxt = HOLD;
            end else if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data <= '0;
         out_chan <= '0;
         rr_ptr   <= '0;
      end else if (load) begin
         out_data <= cand_data;
         out_chan <= cand;
         if (mode) begin
            rr_ptr <= (cand == SEL_W'(CHANNELS - 1)) ? '0 : cand + 1'b1;
         end
      end
   end

`ifdef MUX_NTO1_PARITY_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         out_parity <= 1'b0;
      end else if (load) begin
         out_parity <= ^cand_data;
      end
   end
`endif

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Self-checking bench for mux_nto1_reg: directed scenarios plus randomized traffic vs a reference model.
module tb_mux_nto1_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] in_data;
   logic [7:0]  in_valid;
   logic [7:0]  in_ready;
   logic [2:0]  sel;
   logic        mode;
   logic [7:0]  out_data;
   logic [2:0]  out_chan;
   logic        out_valid;
   logic        out_ready;

   logic [39:0] in_data5;
   logic [4:0]  in_valid5;
   logic [4:0]  in_ready5;
   logic [2:0]  sel5;
   logic        mode5;
   logic [7:0]  out_data5;
   logic [2:0]  out_chan5;
   logic        out_valid5;
   logic        out_ready5;
`ifdef MUX_NTO1_PARITY_EN
   logic        out_parity;
   logic        out_parity5;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mux_nto1_reg #(.WIDTH(8), .CHANNELS(8)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .sel(sel), .mode(mode), .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
`ifdef MUX_NTO1_PARITY_EN
      .out_parity(out_parity),
`endif
      .out_ready(out_ready)
   );

   mux_nto1_reg #(.WIDTH(8), .CHANNELS(5)) dut5 (
      .clk(clk), .rst(rst), .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
      .sel(sel5), .mode(mode5), .out_data(out_data5), .out_chan(out_chan5), .out_valid(out_valid5),
`ifdef MUX_NTO1_PARITY_EN
      .out_parity(out_parity5),
`endif
      .out_ready(out_ready5)
   );

   // Reference model: explicit picks sel if valid; round-robin picks first valid at/after the pointer, else lowest valid.
   logic       m_valid = 1'b0;
   logic [7:0] m_data  = 8'h00;
   logic [2:0] m_chan  = 3'd0;
   int         m_ptr   = 0;

   function automatic int grant_of(input logic md, input logic [2:0] s, input logic [7:0] iv, input int p);
      if (!md) return iv[s] ? int'(s) : -1;
      for (int k = p; k < 8; k++) if (iv[k]) return k;
      for (int k = 0; k < 8; k++) if (iv[k]) return k;
      return -1;
   endfunction

   function automatic logic [7:0] exp_ready(input int g, input logic mv, input logic ordy, input logic r);
      if (r || g < 0 || (mv && !ordy)) return 8'h00;
      return 8'(1 << g);
   endfunction

   always @(posedge clk) begin : model
      int g;
      g = grant_of(mode, sel, in_valid, m_ptr);
      if (rst) begin
         m_valid <= 1'b0;
         m_data  <= 8'h00;
         m_chan  <= 3'd0;
         m_ptr   <= 0;
      end else if (g >= 0 && (!m_valid || out_ready)) begin
         m_valid <= 1'b1;
         m_data  <= in_data[g*8 +: 8];
         m_chan  <= 3'(g);
         if (mode) m_ptr <= (g + 1) % 8;
      end else if (m_valid && out_ready) begin
         m_valid <= 1'b0;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 8'h00; in_valid5 = 5'h00; out_ready = 1'b1; out_ready5 = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; mode = 1'b1; in_valid = 8'hFF; in_valid5 = 5'h1F; mode5 = 1'b1;
      in_data = {$urandom, $urandom}; out_ready = 1'b1; out_ready5 = 1'b1; sel = 3'd0; sel5 = 3'd0;
      in_data5 = {8'h00, $urandom};
      #1;
      n_checks++; if (in_ready !== 8'h00) begin n_fail++; $display("FAIL reset_in_ready: got %h want 00", in_ready); end
      n_checks++; if (in_ready5 !== 5'h00) begin n_fail++; $display("FAIL reset_in_ready5: got %h want 00", in_ready5); end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h want 00", out_data); end
      n_checks++; if (out_chan !== 3'd0) begin n_fail++; $display("FAIL reset_out_chan: got %0d want 0", out_chan); end
      n_checks++; if (out_valid5 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid5: got %b want 0", out_valid5); end
      @(negedge clk);
      rst = 1'b0; in_valid = 8'h00; in_valid5 = 5'h00;
   endtask

   task automatic test_explicit();
      do_reset();
      mode = 1'b0; sel = 3'd3; in_valid = 8'h08; out_ready = 1'b1;
      in_data = {$urandom, $urandom}; in_data[3*8 +: 8] = 8'hA5;
      #1;
      n_checks++; if (in_ready !== 8'h08) begin n_fail++; $display("FAIL expl_in_ready: got %h want 08", in_ready); end
      @(posedge clk); #1;
      n_checks++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL expl_out_data: got %h want a5", out_data); end
      n_checks++; if (out_chan !== 3'd3) begin n_fail++; $display("FAIL expl_out_chan: got %0d want 3", out_chan); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL expl_out_valid: got %b want 1", out_valid); end
      @(negedge clk);
      in_valid = 8'h00;
   endtask

   task automatic test_round_robin_and_backpressure();
      logic [7:0] d [8];
      do_reset();
      for (int k = 0; k < 8; k++) begin
         d[k] = 8'($urandom);
         in_data[k*8 +: 8] = d[k];
      end
      mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         n_checks++; if (out_chan !== 3'(i % 8) || out_valid !== 1'b1 || out_data !== d[i % 8])
            begin n_fail++; $display("FAIL rr_seq[%0d]: got chan %0d vld %b data %h want chan %0d vld 1 data %h", i, out_chan, out_valid, out_data, i % 8, d[i % 8]); end
      end
      @(negedge clk);
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++; if (in_ready !== 8'h00) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %h want 00", i, in_ready); end
         @(posedge clk); #1;
         n_checks++; if (out_chan !== 3'd1 || out_valid !== 1'b1 || out_data !== d[1])
            begin n_fail++; $display("FAIL bp_frozen[%0d]: got chan %0d vld %b data %h want chan 1 vld 1 data %h", i, out_chan, out_valid, out_data, d[1]); end
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      n_checks++; if (in_ready !== 8'h04) begin n_fail++; $display("FAIL bp_release_ready: got %h want 04", in_ready); end
      @(posedge clk); #1;
      n_checks++; if (out_chan !== 3'd2 || out_valid !== 1'b1 || out_data !== d[2])
         begin n_fail++; $display("FAIL bp_release_load: got chan %0d vld %b data %h want chan 2 vld 1 data %h", out_chan, out_valid, out_data, d[2]); end
      @(negedge clk);
      in_valid = 8'h00;
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0 || out_chan !== 3'd2 || out_data !== d[2])
         begin n_fail++; $display("FAIL drain_idle: got vld %b chan %0d data %h want vld 0 chan 2 data %h", out_valid, out_chan, out_data, d[2]); end
   endtask

   task automatic test_skip_wrap();
      do_reset();
      mode = 1'b1; in_valid = 8'h20; out_ready = 1'b1; in_data = {$urandom, $urandom};
      @(posedge clk); #1;
      n_checks++; if (out_chan !== 3'd5) begin n_fail++; $display("FAIL wrap_setup_chan: got %0d want 5", out_chan); end
      @(negedge clk);
      in_valid = 8'b0000_0101;
      #1;
      n_checks++; if (in_ready !== 8'h01) begin n_fail++; $display("FAIL wrap_grant0: got %h want 01", in_ready); end
      @(posedge clk); #1;
      n_checks++; if (out_chan !== 3'd0) begin n_fail++; $display("FAIL wrap_chan0: got %0d want 0", out_chan); end
      @(negedge clk); #1;
      n_checks++; if (in_ready !== 8'h04) begin n_fail++; $display("FAIL wrap_grant2: got %h want 04", in_ready); end
      @(posedge clk); #1;
      n_checks++; if (out_chan !== 3'd2) begin n_fail++; $display("FAIL wrap_chan2: got %0d want 2", out_chan); end
      @(negedge clk);
      in_valid = 8'h00;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      mode = 1'b0; sel = 3'd2; in_valid = 8'h04; out_ready = 1'b0; in_data[2*8 +: 8] = 8'h3C;
      @(posedge clk); #1;
      n_checks++; if (out_data !== 8'h3C || out_valid !== 1'b1)
         begin n_fail++; $display("FAIL mid_setup: got data %h vld %b want 3c 1", out_data, out_valid); end
      @(negedge clk);
      rst = 1'b1; mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
      #1;
      n_checks++; if (in_ready !== 8'h00) begin n_fail++; $display("FAIL mid_rst_ready: got %h want 00", in_ready); end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 3'd0)
         begin n_fail++; $display("FAIL mid_rst_out: got vld %b data %h chan %0d want 0 00 0", out_valid, out_data, out_chan); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++; if (in_ready !== 8'h01) begin n_fail++; $display("FAIL mid_rst_ptr: got ready %h want 01", in_ready); end
      @(negedge clk);
      in_valid = 8'h00;
   endtask

   task automatic test_boundary();
      @(negedge clk);
      mode5 = 1'b0; sel5 = 3'd6; in_valid5 = 5'h1F; out_ready5 = 1'b1; in_data5 = {8'h07, $urandom};
      #1;
      n_checks++; if (in_ready5 !== 5'h00) begin n_fail++; $display("FAIL bnd_sel6_ready: got %h want 00", in_ready5); end
      @(posedge clk); #1;
      n_checks++; if (out_valid5 !== 1'b0) begin n_fail++; $display("FAIL bnd_sel6_valid: got %b want 0", out_valid5); end
      @(negedge clk);
      sel5 = 3'd4;
      #1;
      n_checks++; if (in_ready5 !== 5'h10) begin n_fail++; $display("FAIL bnd_sel4_ready: got %h want 10", in_ready5); end
      @(posedge clk); #1;
      n_checks++; if (out_valid5 !== 1'b1 || out_chan5 !== 3'd4 || out_data5 !== 8'h07)
         begin n_fail++; $display("FAIL bnd_sel4_out: got vld %b chan %0d data %h want 1 4 07", out_valid5, out_chan5, out_data5); end
`ifdef MUX_NTO1_PARITY_EN
      n_checks++; if (out_parity5 !== 1'b1) begin n_fail++; $display("FAIL bnd_parity: got %b want 1", out_parity5); end
`endif
      @(negedge clk);
      in_valid5 = 5'h00;
   endtask

   task automatic test_random();
      int g;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         rst       = ($urandom_range(0, 49) == 0);
         mode      = 1'($urandom);
         sel       = 3'($urandom);
         in_valid  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom & $urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         in_data   = {$urandom, $urandom};
         #1;
         g = grant_of(mode, sel, in_valid, m_ptr);
         n_checks++; if (in_ready !== exp_ready(g, m_valid, out_ready, rst))
            begin n_fail++; $display("FAIL rand_ready[%0d]: got %h want %h", i, in_ready, exp_ready(g, m_valid, out_ready, rst)); end
         @(posedge clk); #1;
         n_checks++; if (out_valid !== m_valid || out_chan !== m_chan || out_data !== m_data)
            begin n_fail++; $display("FAIL rand_out[%0d]: got vld %b chan %0d data %h want vld %b chan %0d data %h", i, out_valid, out_chan, out_data, m_valid, m_chan, m_data); end
`ifdef MUX_NTO1_PARITY_EN
         n_checks++; if (out_parity !== ^m_data)
            begin n_fail++; $display("FAIL rand_parity[%0d]: got %b want %b", i, out_parity, ^m_data); end
`endif
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_data = '0; in_valid = '0; sel = '0; mode = 1'b0; out_ready = 1'b1;
      in_data5 = '0; in_valid5 = '0; sel5 = '0; mode5 = 1'b0; out_ready5 = 1'b1;
      test_reset();
      test_explicit();
      test_round_robin_and_backpressure();
      test_skip_wrap();
      test_reset_mid();
      test_boundary();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_nto1_reg.md
MUX_NTO1_REG -- requirements
Module: mux_nto1_reg

Interface
REQ-001 Parameter WIDTH, default 8: data bits per channel (legal range 1..64).
REQ-002 Parameter CHANNELS, default 8: input channel count (legal range 2..32); SEL_W = clog2(CHANNELS), derived and not overridable.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_data  input  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-006 in_valid  input  CHANNELS  per-channel valid.
REQ-007 in_ready  output  CHANNELS  per-channel accept strobe, combinational.
REQ-008 sel  input  SEL_W  channel index used in explicit mode.
REQ-009 mode  input  1  0 = explicit select, 1 = round-robin.
REQ-010 out_data  output  WIDTH  registered selected data.
REQ-011 out_chan  output  SEL_W  index of the channel held in the output register.
REQ-012 out_valid  output  1  output register holds a word.
REQ-013 out_ready  input  1  downstream accept.

Function
REQ-014 States: IDLE (out_valid=0) and HOLD (out_valid=1); out_valid is the state bit.
REQ-015 load = cand_valid && (!out_valid || out_ready); a word transfers downstream when out_valid && out_ready.
REQ-016 Explicit mode: candidate = sel; cand_valid = in_valid[sel]; sel >= CHANNELS gives cand_valid = 0 and no grant.
REQ-017 Round-robin mode: candidate = first k with in_valid[k]=1, searching rr_ptr, rr_ptr+1, ... CHANNELS-1, 0, ... rr_ptr-1.
REQ-018 in_ready[k] = load && (candidate == k); at most one bit high per cycle; in_ready is never high for an invalid channel.
REQ-019 On load: out_data <= candidate's data, out_chan <= candidate, out_valid <= 1; latency is one cycle from acceptance to out_valid.
REQ-020 On transfer without load: out_valid <= 0 (HOLD->IDLE); out_data and out_chan keep their last values.
REQ-021 Simultaneous transfer and load: the new word replaces the old word in the same edge, state stays HOLD, sustaining one word per cycle.
REQ-022 HOLD with out_ready=0: out_data, out_chan and out_valid are frozen, and in_ready = 0.
REQ-023 rr_ptr (SEL_W bits) updates only on a round-robin-mode load, to candidate+1, wrapping from CHANNELS-1 to 0.
REQ-024 Explicit-mode loads leave rr_ptr unchanged; a mode change takes effect on the same cycle's combinational selection without flushing the held word.
REQ-025 In_valid deassertion without acceptance is tolerated; the block never latches data it did not accept.

Reset
REQ-026 rst high at an edge forces out_valid=0, out_data=0, out_chan=0 and rr_ptr=0, overriding any concurrent load or transfer.
REQ-027 While rst is high, in_ready = 0; a held word is discarded without handshake.

Configuration
REQ-028 Macro MUX_NTO1_PARITY_EN, when defined, adds output out_parity (1 bit) = XOR of out_data, registered alongside out_data, and reset to 0.
REQ-029 When MUX_NTO1_PARITY_EN is undefined, the out_parity port and its logic are absent, and all other behaviour is identical.

Verification
REQ-030 Explicit: mode=0, sel=3, in_valid=8'h08, ch3=8'hA5, out_ready=1 -> in_ready=8'h08, next cycle out_data=8'hA5, out_chan=3, out_valid=1.
REQ-031 Round-robin: mode=1, in_valid=8'hFF held, out_ready=1 for 10 cycles -> out_chan sequence 0,1,...,7,0,1 at one word per cycle.
REQ-032 Backpressure: word in HOLD, out_ready=0 for 4 cycles, in_valid=8'hFF -> outputs frozen, in_ready=0; out_ready=1 -> next word loads on the same edge as the transfer.
REQ-033 Skip/wrap: mode=1, rr_ptr=6, in_valid=8'b0000_0101 -> grant 0, then rr_ptr=1, and the next grant is 2.
REQ-034 Reset mid-op: HOLD with out_data=8'h3C, rst=1 for one cycle while in_valid=8'hFF -> out_valid=0, out_data=0, rr_ptr=0, and in_ready=0 during reset.
REQ-035 Boundary/config: CHANNELS=5, sel=6, in_valid=5'h1F -> no grant, out_valid stays 0; with MUX_NTO1_PARITY_EN, loading 8'h07 -> out_parity=1.
